wall_slice_renderer: RTL
========================

Name: wall_slice_renderer

Overview:
Sits directly downstream of the wall tracer. It consumes the per-line wall half-size and side, and turns them into per-pixel region codes (ceiling, wall, floor, blank) and a 6-bit texture V coordinate along the scanline. The per-line texture step and the clip offset are computed by a multi-cycle divide and multiply during the line after capture. The result is double-buffered and swapped on hmax, giving exactly one line of latency.

Parameters:
H_VIEW, 640, visible pixels per line; hpos >= H_VIEW is blank.
H_BITS, 10, width of hpos.
SIZE_BITS, 11, width of i_size (wall half-size, integer pixels).
STEP_FRAC, 10, fractional bits of texture step/accumulator (Q6.STEP_FRAC, 16 bits total by default).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
hpos  in  H_BITS  horizontal pixel counter, 0..799
hmax  in  1  high for the last cycle of each line
i_size  in  SIZE_BITS  wall half-size from tracer; valid from the cycle after hmax
i_side  in  1  wall side from tracer; same timing as i_size
o_region  out  2  0=BLANK, 1=CEIL, 2=WALL, 3=FLOOR
o_side  out  1  side of the wall currently displayed
o_texv  out  6  texture V coordinate; 0 outside WALL
o_late  out  1  one-cycle pulse: swap occurred before compute finished

Behaviour:
- Reset (async, reset_n=0):
  - o_region=0, o_side=0, o_texv=0, o_late=0.
  - FSM goes to IDLE.
  - Work and display registers are cleared: size=0, step=0, init=0, side=0.
  - Asserting reset mid-compute abandons the compute immediately.
- Capture:
  - hmax_d is hmax delayed by one register.
  - When hmax_d=1: latch i_size and i_side into work regs; FSM IDLE->LATCH.
- FSM (work side), states IDLE, LATCH, DIV, MUL, DONE:
  - LATCH: compute clip = max(0, size - H_VIEW/2) (SIZE_BITS wide).
    - size==0: step=0, init=0, go to DONE.
    - Otherwise go to DIV.
  - DIV: restoring divide, 1 quotient bit/cycle, 16 cycles.
    - step = floor(2^(6+STEP_FRAC) / (2*size)).
    - size=1 gives 32768.
  - MUL: shift-add, 1 bit/cycle, SIZE_BITS cycles.
    - init = (clip*step) mod 2^16.
  - DONE: hold until swap.
  - A new capture (hmax_d) in any state restarts from LATCH.
- Swap, on hmax:
  - If FSM==DONE: display regs <= work regs (size, side, step, init); FSM -> IDLE.
  - If FSM!=DONE: display regs keep their old values; o_late=1 for one cycle; FSM continues working.
- Pixel side; all outputs registered, 1-cycle latency from hpos:
  - top = max(0, H_VIEW/2 - dsize); bot = min(H_VIEW, H_VIEW/2 + dsize). top is inclusive, bot is exclusive.
  - Region: hpos>=H_VIEW -> BLANK; hpos<top -> CEIL; hpos<bot -> WALL; else FLOOR.
  - dsize==0: empty wall, so CEIL for 0..319 and FLOOR for 320..639.
  - Texture accumulator acc (16 bits):
    - loads dinit when hpos==0;
    - adds dstep after each WALL pixel;
    - wraps mod 2^16, i.e. texture wraps at 64.
  - o_texv = acc[STEP_FRAC+5:STEP_FRAC] on WALL pixels, else 0.
  - o_side = display side.
- Timing: a tracer result presented at hmax of line N is rendered on line N+2. Compute worst case is about 30 cycles, well under 800.

Optional Feature:
- Macro: RENDER_STATE_DEBUG_EN.
- Defined: adds output port o_state[2:0] exposing the FSM state encoding (IDLE=0, LATCH=1, DIV=2, MUL=3, DONE=4).
- Undefined: no port and no extra logic; all other behaviour is identical.

Decomposition:
- Shared package: region codes (BLANK/CEIL/WALL/FLOOR), FSM state encodings, H_VIEW/H_CENTER constants, STEP_FRAC, and the texture width of 6.
- One natural sub-module: seq_divider.
  - Restoring divider: 16-bit quotient, start/done handshake, async active-low reset.
  - Instantiated for DIV. The multiply stays inline.

Test Plan:
- Reset asserted mid-DIV -> all outputs 0 immediately; after release, with no valid capture, o_region is CEIL for hpos 0..319, FLOOR for 320..639, BLANK for 640..799.
- i_size=100, i_side=1 captured -> two lines later:
  - step=327;
  - WALL for hpos 220..419;
  - o_texv=0 at 220, 63 at 419;
  - o_side=1.
- i_size=400 -> step=81, clip=80, init=6480; WALL covers 0..639; o_texv=6 at hpos 0.
- i_size=2047 -> step=16, clip=1727, init=27632; o_texv=26 at hpos 0; no FLOOR or CEIL pixels.
- i_size=0 -> no WALL pixels; o_texv stays 0 for the entire line.
- hmax forced 10 cycles after capture (compute unfinished) -> o_late pulses once; the previous line's display is repeated; the next normal swap shows the new result.

Source files
------------

// File: rtl/wall_slice_renderer_pkg.sv
// Shared constants and encodings for the wall slice renderer and its helpers.
package wall_slice_renderer_pkg;

   localparam int H_VIEW    = 640;
   localparam int H_CENTER  = H_VIEW / 2;
   localparam int H_BITS    = 10;
   localparam int SIZE_BITS = 11;
   localparam int STEP_FRAC = 10;
   localparam int TEX_BITS  = 6;

   typedef enum logic [1:0] {
      REG_BLANK = 2'd0,
      REG_CEIL  = 2'd1,
      REG_WALL  = 2'd2,
      REG_FLOOR = 2'd3
   } region_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LATCH = 3'd1,
      ST_DIV   = 3'd2,
      ST_MUL   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/wall_slice_renderer_seq_divider.sv
// Restoring divider, one quotient bit per cycle, start/done handshake.
// Caller guarantees numer >> Q_BITS < denom so the quotient fits in Q_BITS bits.
module seq_divider #(
   parameter int Q_BITS = 16,
   parameter int D_BITS = 12
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [Q_BITS:0]   numer,
   input  logic [D_BITS-1:0] denom,
   output logic              done,
   output logic [Q_BITS-1:0] quot
);

   localparam int CNT_BITS = $clog2(Q_BITS + 1);

   logic [D_BITS-1:0]   rem_reg;
   logic [Q_BITS-1:0]   sh_reg;
   logic [CNT_BITS-1:0] cnt_reg;
   logic                busy_reg;
   logic                done_reg;
   logic [D_BITS:0]     trial;
   logic [D_BITS:0]     diff;
   logic                qbit;

   always_comb begin
      trial = {rem_reg, sh_reg[Q_BITS-1]};
      qbit  = (trial >= {1'b0, denom});
      diff  = qbit ? (trial - {1'b0, denom}) : trial;
   end

   // sh_reg shifts dividend bits out the top while quotient bits enter at the bottom
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rem_reg  <= '0;
         sh_reg   <= '0;
         cnt_reg  <= '0;
         busy_reg <= 1'b0;
         done_reg <= 1'b0;
      end else if (start) begin
         rem_reg  <= {{(D_BITS-1){1'b0}}, numer[Q_BITS]};
         sh_reg   <= numer[Q_BITS-1:0];
         cnt_reg  <= CNT_BITS'(Q_BITS);
         busy_reg <= 1'b1;
         done_reg <= 1'b0;
      end else if (busy_reg) begin
         rem_reg <= diff[D_BITS-1:0];
         sh_reg  <= {sh_reg[Q_BITS-2:0], qbit};
         cnt_reg <= cnt_reg - CNT_BITS'(1);
         if (cnt_reg == CNT_BITS'(1)) begin
            busy_reg <= 1'b0;
            done_reg <= 1'b1;
         end
      end else begin
         done_reg <= 1'b0;
      end
   end

   assign done = done_reg;
   assign quot = sh_reg;

endmodule

// File: rtl/wall_slice_renderer.sv
// Turns per-line wall half-size/side into per-pixel region codes and texture V, one line late.
// Define RENDER_STATE_DEBUG_EN to add the o_state port exposing the work FSM state.
module wall_slice_renderer #(
   parameter int H_VIEW    = wall_slice_renderer_pkg::H_VIEW,
   parameter int H_BITS    = wall_slice_renderer_pkg::H_BITS,
   parameter int SIZE_BITS = wall_slice_renderer_pkg::SIZE_BITS,
   parameter int STEP_FRAC = wall_slice_renderer_pkg::STEP_FRAC
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [H_BITS-1:0]    hpos,
   input  logic                 hmax,
   input  logic [SIZE_BITS-1:0] i_size,
   input  logic                 i_side,
   output logic [1:0]           o_region,
   output logic                 o_side,
   output logic [5:0]           o_texv,
   output logic                 o_late
`ifdef RENDER_STATE_DEBUG_EN
   ,
   output logic [2:0]           o_state
`endif
);

   import wall_slice_renderer_pkg::*;

   localparam int ACC_BITS  = TEX_BITS + STEP_FRAC;
   localparam int MCNT_BITS = $clog2(SIZE_BITS);
   localparam logic [SIZE_BITS-1:0] CENTER_S = SIZE_BITS'(H_VIEW / 2);
   localparam logic [SIZE_BITS:0]   CENTER_W = (SIZE_BITS + 1)'(H_VIEW / 2);
   localparam logic [SIZE_BITS:0]   VIEW_W   = (SIZE_BITS + 1)'(H_VIEW);
   localparam logic [ACC_BITS:0]    STEP_NUM = {1'b1, {ACC_BITS{1'b0}}};

   state_t               state_reg, state_next;
   logic                 hmax_d_reg;
   logic [SIZE_BITS-1:0] wsize_reg, dsize_reg, mul_b_reg, clip;
   logic                 wside_reg, dside_reg;
   logic [ACC_BITS-1:0]  wstep_reg, winit_reg, mul_a_reg;
   logic [ACC_BITS-1:0]  dstep_reg, dinit_reg, acc_reg, acc_next, tex_cur;
   logic [MCNT_BITS-1:0] mcnt_reg;
   logic                 div_start, div_done, swap;
   logic [ACC_BITS-1:0]  div_quot;
   logic [SIZE_BITS:0]   hpos_x, top, bot;
   logic [1:0]           region_next;
   logic [TEX_BITS-1:0]  texv_next;

   seq_divider #(
      .Q_BITS(ACC_BITS),
      .D_BITS(SIZE_BITS + 1)
   ) u_div (
      .clk    (clk),
      .reset_n(reset_n),
      .start  (div_start),
      .numer  (STEP_NUM),
      .denom  ({wsize_reg, 1'b0}),
      .done   (div_done),
      .quot   (div_quot)
   );

   assign clip = (wsize_reg > CENTER_S) ? (wsize_reg - CENTER_S) : '0;
   assign swap = hmax && (state_reg == ST_DONE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_reg <= ST_IDLE;
      else          state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      div_start  = 1'b0;
      case (state_reg)
         ST_IDLE: ;
         ST_LATCH: begin
            if (wsize_reg == '0) begin
               state_next = ST_DONE;
            end else begin
               state_next = ST_DIV;
               div_start  = 1'b1;
            end
         end
         ST_DIV:  if (div_done) state_next = ST_MUL;
         ST_MUL:  if (mcnt_reg == MCNT_BITS'(SIZE_BITS - 1)) state_next = ST_DONE;
         ST_DONE: ;
         default: state_next = ST_IDLE;
      endcase
      if (swap)       state_next = ST_IDLE;
      // a fresh capture always wins, abandoning whatever was in flight
      if (hmax_d_reg) state_next = ST_LATCH;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hmax_d_reg <= 1'b0;
         wsize_reg  <= '0;
         wside_reg  <= 1'b0;
         wstep_reg  <= '0;
         winit_reg  <= '0;
         mul_a_reg  <= '0;
         mul_b_reg  <= '0;
         mcnt_reg   <= '0;
      end else begin
         hmax_d_reg <= hmax;
         if (hmax_d_reg) begin
            wsize_reg <= i_size;
            wside_reg <= i_side;
         end
         case (state_reg)
            ST_LATCH: begin
               wstep_reg <= '0;
               winit_reg <= '0;
               mul_b_reg <= clip;
            end
            ST_DIV: begin
               if (div_done) begin
                  wstep_reg <= div_quot;
                  mul_a_reg <= div_quot;
                  mcnt_reg  <= '0;
               end
            end
            ST_MUL: begin
               if (mul_b_reg[0]) winit_reg <= winit_reg + mul_a_reg;
               mul_a_reg <= mul_a_reg << 1;
               mul_b_reg <= mul_b_reg >> 1;
               mcnt_reg  <= mcnt_reg + MCNT_BITS'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dsize_reg <= '0;
         dside_reg <= 1'b0;
         dstep_reg <= '0;
         dinit_reg <= '0;
      end else if (swap) begin
         dsize_reg <= wsize_reg;
         dside_reg <= wside_reg;
         dstep_reg <= wstep_reg;
         dinit_reg <= winit_reg;
      end
   end

   always_comb begin
      hpos_x = (SIZE_BITS + 1)'(hpos);
      if ({1'b0, dsize_reg} >= CENTER_W) begin
         top = '0;
         bot = VIEW_W;
      end else begin
         top = CENTER_W - {1'b0, dsize_reg};
         bot = CENTER_W + {1'b0, dsize_reg};
      end
      region_next = REG_FLOOR;
      if (hpos_x >= VIEW_W)   region_next = REG_BLANK;
      else if (hpos_x < top)  region_next = REG_CEIL;
      else if (hpos_x < bot)  region_next = REG_WALL;
      // the texture coordinate of a pixel is the accumulator before its own step
      tex_cur   = (hpos == '0) ? dinit_reg : acc_reg;
      acc_next  = tex_cur;
      texv_next = '0;
      if (region_next == REG_WALL) begin
         acc_next  = tex_cur + dstep_reg;
         texv_next = tex_cur[ACC_BITS-1:STEP_FRAC];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_reg  <= '0;
         o_region <= REG_BLANK;
         o_texv   <= '0;
         o_side   <= 1'b0;
         o_late   <= 1'b0;
      end else begin
         acc_reg  <= acc_next;
         o_region <= region_next;
         o_texv   <= texv_next;
         o_side   <= dside_reg;
         o_late   <= hmax && (state_reg != ST_DONE);
      end
   end

`ifdef RENDER_STATE_DEBUG_EN
   assign o_state = state_reg;
`endif

endmodule
